mips_dump_sequencer: RTL and testbench
======================================

// Module: mips_dump_sequencer
// PURPOSE
//  Sequences the post-halt state dump of the MIPS pipeline to the UART TX FIFO.
//  On a start pulse it walks the shared debug address bus over the PC, register file and data memory.
//  It captures each 32-bit word and serializes it MSB-first as 4 bytes into the TX FIFO, with a framing header byte first.
//  It sits between the pipeline debug read ports (o_dunit_reg / o_dunit_mem_data) and the TX FIFO, under debug-unit command control.
// PARAMETERS
//  NB_REG      32    word width of PC / register / memory read data
//  NB_BYTE     8     TX FIFO data width
//  N_REGS      32    register-file words dumped (index 0..N_REGS-1)
//  N_MEM_WORDS 32    data-memory words dumped (word index 0..N_MEM_WORDS-1)
//  HDR_BYTE    8'hA5 framing byte sent before the first data byte
// PORTS
//  i_clk       in   1        system clock (clk_50mhz domain)
//  i_reset     in   1        synchronous reset, active-low
//  i_start     in   1        1-cycle dump request; ignored unless IDLE
//  i_abort     in   1        stop dump, return to IDLE, no o_done
//  i_pc        in   NB_REG   current PC, sampled once per dump
//  i_reg_data  in   NB_REG   register-file read data, valid 1 cycle after o_addr
//  i_mem_data  in   NB_REG   data-memory read data, valid 1 cycle after o_addr
//  i_tx_full   in   1        TX FIFO full
//  o_tx_wr     out  1        TX FIFO write strobe (byte accepted on the edge where it is 1)
//  o_tx_data   out  NB_BYTE  byte to TX FIFO
//  o_addr      out  NB_REG   word index on the shared debug read bus
//  o_busy      out  1        high in every state except IDLE; gates pipeline clock enable low
//  o_done      out  1        1-cycle pulse after the last byte is written
// BEHAVIOUR
//  Reset (i_reset==0 at an edge): state=IDLE; o_addr=0, o_tx_data=0, o_busy=0, o_done=0; counters=0.
//  o_tx_wr is 0 in reset.
//  States: IDLE -> HDR -> SET_ADDR -> CAPTURE -> SEND -> (SET_ADDR | FIN) -> IDLE.
//  IDLE: i_start & !i_abort -> HDR; sect=PC, idx=0.
//  HDR: o_tx_data=HDR_BYTE; o_tx_wr=!i_tx_full (combinational); on write -> SET_ADDR.
//  SET_ADDR: drive o_addr=idx (zero-extended); o_addr holds through CAPTURE and SEND.
//  CAPTURE: load word shift reg from i_pc (sect PC), i_reg_data (REG) or i_mem_data (MEM); byte_cnt=0 -> SEND.
//  SEND: o_tx_data=shreg[NB_REG-1 -: NB_BYTE]; o_tx_wr=!i_tx_full.
//  Each write shifts left 8 and increments byte_cnt; i_tx_full stalls with no write and no shift.
//  After the 4th byte: advance idx/sect.
//  Order: PC once, then REG idx 0..N_REGS-1, then MEM idx 0..N_MEM_WORDS-1.
//  After the last MEM word -> FIN.
//  FIN: o_done=1 for exactly one cycle -> IDLE.
//  Total bytes per dump = 1 + 4*(1+N_REGS+N_MEM_WORDS) = 261 at defaults.
//  Read latency fixed at 1 cycle (registered read on pipeline debug ports); no valid handshake.
//  i_abort in any non-IDLE state: next state IDLE.
//  A write already accepted on that edge stands; no further writes; o_done stays 0.
//  i_start while busy: ignored. i_start & i_abort same cycle in IDLE: abort wins, stay IDLE.
//  Reset mid-dump: immediate IDLE; no partial word is resumed.
//  idx wrap: idx counts 0..max-1 per section and clears on section change; never wraps within a section.
//  o_addr never exceeds max(N_REGS,N_MEM_WORDS)-1.
//  TX FIFO full for an arbitrary time: the sequencer holds SEND/HDR indefinitely, with o_addr and o_tx_data stable.
// STRUCTURE
//  Package mips_dbg_pkg: state enum (IDLE,HDR,SET_ADDR,CAPTURE,SEND,FIN), section enum (SEC_PC,SEC_REG,SEC_MEM).
//  The package also holds the HDR_BYTE default and the BYTES_PER_WORD = NB_REG/NB_BYTE constant.
//  Sub-module dump_word_serializer: parallel load, byte shift-out on accept, last_byte flag.
//  The FSM and address counters stay in this module.
// TESTING
//  T1 i_pc=0x00400010, regs[k]=k, mem[k]=0x1000+k, FIFO never full, start pulse -> 261 writes.
//     Required sequence: A5; 00 40 00 10; 00 00 00 00 ... 00 00 00 1F; 00 00 10 00 ... 00 00 10 1F.
//     o_done pulses once, 1 cycle after the last write.
//  T2 i_tx_full high for 7 cycles during the 3rd byte of reg 5 -> no o_tx_wr in that window.
//     o_tx_data=0x00 and o_addr=5 stay stable; dump resumes with byte order intact.
//  T3 i_start pulsed again mid-dump (reg 10) -> ignored; still exactly 261 bytes and one o_done.
//  T4 i_abort asserted at mem idx 3 -> IDLE next cycle, o_busy=0, no o_done.
//     A subsequent start produces a full 261-byte dump from A5.
//  T5 i_reset=0 for 1 cycle mid-SEND -> all outputs 0 next cycle, state IDLE.
//     Same-cycle i_start & i_abort in IDLE -> no activity.
//  T6 N_REGS=4, N_MEM_WORDS=2 -> 29 bytes; o_addr sequence 0,0,1,2,3,0,1.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared types and defaults for the post-halt debug dump path.
// State/section encodings plus the framing byte and word-to-byte ratio.
package mips_dbg_pkg;

  localparam int              NB_REG_DEF     = 32;
  localparam int              NB_BYTE_DEF    = 8;
  localparam int              BYTES_PER_WORD = NB_REG_DEF / NB_BYTE_DEF;
  localparam logic [7:0]      HDR_BYTE_DEF   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    SET_ADDR = 3'd2,
    CAPTURE  = 3'd3,
    SEND     = 3'd4,
    FIN      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_REG = 2'd1,
    SEC_MEM = 2'd2
  } sect_e;

endpackage

// File: rtl/dump_word_serializer.sv
// Word-to-byte shifter: parallel load, MSB byte presented at once, one byte per accept.
// Holds byte and count while no accept arrives, so a stalled sink sees a stable byte.
module dump_word_serializer #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_REG-1:0]  i_load_data,
  input  logic               i_shift,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_last_byte
);

  localparam int BPW   = NB_REG / NB_BYTE;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [NB_REG-1:0] shreg;
  logic [CNT_W-1:0]  byte_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (i_load) begin
      shreg    <= i_load_data;
      byte_cnt <= '0;
    end else if (i_shift) begin
      shreg    <= shreg << NB_BYTE;
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  assign o_byte      = shreg[NB_REG-1 -: NB_BYTE];
  assign o_last_byte = (byte_cnt == CNT_W'(BPW - 1));

endmodule

// File: rtl/mips_dump_sequencer.sv
// Dumps PC, register file and data memory as a header byte plus MSB-first words into the TX FIFO.
// One-cycle registered read per word; a full FIFO freezes HDR/SEND with address and byte held.
module mips_dump_sequencer
  import mips_dbg_pkg::*;
#(
  parameter int                 NB_REG      = NB_REG_DEF,
  parameter int                 NB_BYTE     = NB_BYTE_DEF,
  parameter int                 N_REGS      = 32,
  parameter int                 N_MEM_WORDS = 32,
  parameter logic [NB_BYTE-1:0] HDR_BYTE    = NB_BYTE'(HDR_BYTE_DEF)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_REG-1:0]  i_pc,
  input  logic [NB_REG-1:0]  i_reg_data,
  input  logic [NB_REG-1:0]  i_mem_data,
  input  logic               i_tx_full,
  output logic               o_tx_wr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic [NB_REG-1:0]  o_addr,
  output logic               o_busy,
  output logic               o_done
);

  localparam int MAX_IDX = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
  localparam int IDX_W   = (MAX_IDX > 1) ? $clog2(MAX_IDX) : 1;

  state_e              state;
  sect_e               sect;
  logic [IDX_W-1:0]    idx;
  logic                tx_wr;
  logic [NB_REG-1:0]   load_data;
  logic [NB_BYTE-1:0]  ser_byte;
  logic                last_byte;

  // Write strobe is masked during reset so no byte escapes on the reset edge.
  assign tx_wr = i_reset && !i_tx_full && (state == HDR || state == SEND);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= IDLE;
      sect  <= SEC_PC;
      idx   <= '0;
    end else if (state != IDLE && i_abort) begin
      state <= IDLE;
      sect  <= SEC_PC;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (i_start && !i_abort) begin
          state <= HDR;
          sect  <= SEC_PC;
          idx   <= '0;
        end
        HDR:      if (tx_wr) state <= SET_ADDR;
        SET_ADDR: state <= CAPTURE;
        CAPTURE:  state <= SEND;
        SEND: if (tx_wr && last_byte) begin
          state <= SET_ADDR;
          case (sect)
            SEC_PC: begin
              sect <= SEC_REG;
              idx  <= '0;
            end
            SEC_REG: begin
              if (idx == IDX_W'(N_REGS - 1)) begin
                sect <= SEC_MEM;
                idx  <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
            default: begin
              if (idx == IDX_W'(N_MEM_WORDS - 1)) begin
                state <= FIN;
                idx   <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          endcase
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    load_data = i_pc;
    case (sect)
      SEC_REG: load_data = i_reg_data;
      SEC_MEM: load_data = i_mem_data;
      default: load_data = i_pc;
    endcase
  end

  dump_word_serializer #(
    .NB_REG  (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (state == CAPTURE),
    .i_load_data (load_data),
    .i_shift     (state == SEND && tx_wr),
    .o_byte      (ser_byte),
    .o_last_byte (last_byte)
  );

  always_comb begin
    o_tx_data = '0;
    case (state)
      HDR:     o_tx_data = HDR_BYTE;
      SEND:    o_tx_data = ser_byte;
      default: o_tx_data = '0;
    endcase
  end

  assign o_tx_wr = tx_wr;
  assign o_addr  = NB_REG'(idx);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == FIN);

endmodule

// File: tb/tb_mips_dump_sequencer.sv
// Scoreboard bench: a byte/address model of each dump is queued at start, monitors pop per TX write.
module tb_mips_dump_sequencer;
  import mips_dbg_pkg::*;

  typedef struct packed {
    logic [7:0]  dat;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start0, start1, abort, full;
  logic [31:0] pc;
  logic [31:0] regs [32];
  logic [31:0] mem  [32];
  logic [31:0] rd_reg0, rd_mem0, rd_reg1, rd_mem1;
  logic        wr0, wr1, busy0, busy1, done0, done1;
  logic [7:0]  dat0, dat1;
  logic [31:0] addr0, addr1;

  exp_t q0[$];
  exp_t q1[$];
  int   wr_cnt [2];
  int   done_cnt [2];
  logic prev_wr [2];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mips_dump_sequencer dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start0), .i_abort(abort), .i_pc(pc),
    .i_reg_data(rd_reg0), .i_mem_data(rd_mem0), .i_tx_full(full),
    .o_tx_wr(wr0), .o_tx_data(dat0), .o_addr(addr0), .o_busy(busy0), .o_done(done0)
  );

  mips_dump_sequencer #(.N_REGS(4), .N_MEM_WORDS(2)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .i_abort(abort), .i_pc(pc),
    .i_reg_data(rd_reg1), .i_mem_data(rd_mem1), .i_tx_full(full),
    .o_tx_wr(wr1), .o_tx_data(dat1), .o_addr(addr1), .o_busy(busy1), .o_done(done1)
  );

  // Pipeline debug ports: registered read, one cycle after the address.
  always @(posedge clk) begin
    rd_reg0 <= regs[addr0[4:0]];
    rd_mem0 <= mem[addr0[4:0]];
    rd_reg1 <= regs[addr1[4:0]];
    rd_mem1 <= mem[addr1[4:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exp(input int d, input logic [7:0] b, input logic [31:0] a);
    exp_t e;
    e.dat  = b;
    e.addr = a;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_word(input int d, input logic [31:0] w, input int a);
    for (int b = 0; b < BYTES_PER_WORD; b++)
      push_exp(d, 8'(w >> (8 * (BYTES_PER_WORD - 1 - b))), 32'(a));
  endtask

  // Reference dump: header, PC, registers, memory in plain index order.
  task automatic push_dump(input int d, input int nr, input int nm);
    push_exp(d, HDR_BYTE_DEF, 32'd0);
    push_word(d, pc, 0);
    for (int k = 0; k < nr; k++) push_word(d, regs[k], k);
    for (int k = 0; k < nm; k++) push_word(d, mem[k], k);
  endtask

  task automatic mon(input int d, input logic wr, input logic [7:0] dat,
                     input logic [31:0] addr, input logic done);
    exp_t e;
    if (wr) begin
      if (qsize(d) == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk("tx_byte", 32'(dat), 32'(e.dat));
        chk("addr_at_byte", addr, e.addr);
      end
      wr_cnt[d]++;
    end
    if (done) begin
      done_cnt[d]++;
      chk("done_after_last_write", {30'd0, prev_wr[d], qsize(d) == 0}, 32'd3);
    end
    prev_wr[d] = wr;
  endtask

  always @(negedge clk) mon(0, wr0, dat0, addr0, done0);
  always @(negedge clk) mon(1, wr1, dat1, addr1, done1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plain_data();
    pc = 32'h0040_0010;
    for (int k = 0; k < 32; k++) begin
      regs[k] = 32'(k);
      mem[k]  = 32'h1000 + 32'(k);
    end
  endtask

  task automatic set_rand_data();
    pc = $urandom;
    for (int k = 0; k < 32; k++) begin
      regs[k] = $urandom;
      mem[k]  = $urandom;
    end
  endtask

  task automatic begin_dump(input int d, input int nr, input int nm);
    wr_cnt[d]   = 0;
    done_cnt[d] = 0;
    push_dump(d, nr, nm);
    if (d == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_wr(input int d, input int n);
    int i = 0;
    while (wr_cnt[d] < n && i < 5000) begin
      tick();
      i++;
    end
    chk("write_count_reached", 32'(wr_cnt[d] >= n), 32'd1);
  endtask

  task automatic wait_done(input int d);
    int i = 0;
    while (done_cnt[d] == 0 && i < 5000) begin
      tick();
      i++;
    end
    chk("done_seen", 32'(done_cnt[d] != 0), 32'd1);
  endtask

  task automatic end_dump(input int d, input int nbytes);
    repeat (3) tick();
    chk("bytes_per_dump", 32'(wr_cnt[d]), 32'(nbytes));
    chk("done_pulses", 32'(done_cnt[d]), 32'd1);
    chk("queue_drained", 32'(qsize(d)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; full = 1'b0;
    prev_wr[0] = 1'b0; prev_wr[1] = 1'b0;
    wr_cnt[0] = 0; wr_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
    set_plain_data();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_addr", addr0, 32'd0);
    chk("rst_data", 32'(dat0), 32'd0);
    chk("rst_wr", 32'(wr0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_busy_small", 32'(busy1), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Full dump, FIFO never full.
    begin_dump(0, 32, 32);
    wait_done(0);
    end_dump(0, 261);

    // FIFO full for 7 cycles on the 3rd byte of reg 5.
    begin_dump(0, 32, 32);
    wait_wr(0, 1 + 4 * 6 + 2);
    full = 1'b1;
    repeat (7) begin
      @(negedge clk);
      chk("stall_no_write", 32'(wr0), 32'd0);
      chk("stall_addr", addr0, 32'd5);
      chk("stall_data", 32'(dat0), 32'h00);
      tick();
    end
    full = 1'b0;
    wait_done(0);
    end_dump(0, 261);

    // Start pulse during reg 10 is ignored.
    begin_dump(0, 32, 32);
    wait_wr(0, 1 + 4 * 11);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done(0);
    end_dump(0, 261);

    // Abort during mem word 3: the in-flight byte stands, then silence.
    set_rand_data();
    begin_dump(0, 32, 32);
    wait_wr(0, 1 + 4 * 36 + 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    repeat (10) tick();
    chk("abort_bytes", 32'(wr_cnt[0]), 32'd147);
    chk("abort_no_done", 32'(done_cnt[0]), 32'd0);
    set_rand_data();
    begin_dump(0, 32, 32);
    wait_done(0);
    end_dump(0, 261);

    // Reset mid-SEND, then simultaneous start and abort in IDLE.
    set_rand_data();
    begin_dump(0, 32, 32);
    wait_wr(0, 20);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_addr", addr0, 32'd0);
    chk("midrst_data", 32'(dat0), 32'd0);
    chk("midrst_wr", 32'(wr0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_bytes", 32'(wr_cnt[0]), 32'd20);
    tick();
    start0 = 1'b1;
    abort  = 1'b1;
    tick();
    start0 = 1'b0;
    abort  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("start_abort_idle", 32'(busy0), 32'd0);
      tick();
    end

    // Small configuration: 4 registers, 2 memory words.
    set_rand_data();
    begin_dump(1, 4, 2);
    wait_done(1);
    end_dump(1, 29);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
